// File: rtl/io_timer_pkg.sv
// io_timer_pkg: register offsets, CTRL/STATUS bit indices and FSM state type for io_timer
package io_timer_pkg;
  localparam logic [7:0] OFS_CTRL    = 8'd0;
  localparam logic [7:0] OFS_PRESC   = 8'd1;
  localparam logic [7:0] OFS_RELOAD  = 8'd2;
  localparam logic [7:0] OFS_COUNT   = 8'd3;
  localparam logic [7:0] OFS_STATUS  = 8'd4;
  localparam logic [7:0] OFS_CAPTURE = 8'd5;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_OVF_IE  = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_CAP_IE  = 3;
  localparam int ST_OVF = 0;
  localparam int ST_CAP = 1;
  localparam int ST_RUN = 2;
  typedef enum logic {STOP, RUN} io_timer_state_e;
endpackage

// File: rtl/io_timer_prescaler.sv
// io_timer_prescaler: tick_o every presc_i+1 clocks while run_i (clk_i, rst_i, run_i, clr_i, presc_i, tick_o)
module io_timer_prescaler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       clr_i,
  input  logic [7:0] presc_i,
  output logic       tick_o
);
  logic [7:0] pcnt;
  assign tick_o = run_i && pcnt == presc_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pcnt <= '0;
    else pcnt <= (clr_i || tick_o) ? '0 : run_i ? pcnt + 8'd1 : pcnt;
endmodule

// File: rtl/io_timer.sv
// io_timer: port-I/O down-counting timer (clk_i, rst_i, io_addr_i, io_data_i, io_we_i, io_data_o, irq_o, capture_i used only with IO_TIMER_CAPTURE_EN)
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter logic [7:0] RELOAD_RST = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] io_addr_i,
  input  logic [7:0] io_data_i,
  input  logic       io_we_i,
  output logic [7:0] io_data_o,
  output logic       irq_o,
  input  logic       capture_i
);
  io_timer_state_e state, state_nxt;
  logic [3:0] ctrl;
  logic [7:0] presc, reload, count, capture, ofs, status;
  logic ovf, cap, sel, wr, tick, hit, os_stop, cap_set;
  logic ctrl_wr, presc_wr, reload_wr, count_wr, status_wr;
  assign ofs       = io_addr_i - BASE_ADDR;
  assign sel       = ofs <= OFS_CAPTURE;
  assign wr        = io_we_i && sel;
  assign ctrl_wr   = wr && ofs == OFS_CTRL;
  assign presc_wr  = wr && ofs == OFS_PRESC;
  assign reload_wr = wr && ofs == OFS_RELOAD;
  assign count_wr  = wr && ofs == OFS_COUNT;
  assign status_wr = wr && ofs == OFS_STATUS;
  assign hit       = tick && !count_wr && count == 8'h00;
  assign os_stop   = hit && ctrl[CTRL_ONESHOT] && !ctrl_wr;
  assign irq_o     = (ovf && ctrl[CTRL_OVF_IE]) || (cap && ctrl[CTRL_CAP_IE]);
  io_timer_prescaler u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run_i  (state == RUN),
    .clr_i  (presc_wr || (ctrl_wr && io_data_i[CTRL_EN] && state == STOP)),
    .presc_i(presc),
    .tick_o (tick)
  );
  always_comb begin
    state_nxt = ctrl_wr ? (io_data_i[CTRL_EN] ? RUN : STOP) : os_stop ? STOP : state;
    status = 8'h00;
    status[ST_OVF] = ovf;
    status[ST_CAP] = cap;
    status[ST_RUN] = state == RUN;
  end
  assign io_data_o = !sel                ? 8'h00 :
                     ofs == OFS_CTRL     ? {4'h0, ctrl} :
                     ofs == OFS_PRESC    ? presc :
                     ofs == OFS_RELOAD   ? reload :
                     ofs == OFS_COUNT    ? count :
                     ofs == OFS_STATUS   ? status : capture;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state  <= STOP;
      ctrl   <= '0;
      presc  <= '0;
      reload <= RELOAD_RST;
      count  <= RELOAD_RST;
      ovf    <= 1'b0;
      cap    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ctrl   <= ctrl_wr ? io_data_i[3:0] : os_stop ? ctrl & ~(4'b1 << CTRL_EN) : ctrl;
      presc  <= presc_wr ? io_data_i : presc;
      reload <= reload_wr ? io_data_i : reload;
      count  <= count_wr ? io_data_i : hit ? reload : (tick ? count - 8'd1 : count);
      ovf    <= hit || (ovf && !(status_wr && io_data_i[ST_OVF]));
      cap    <= cap_set || (cap && !(status_wr && io_data_i[ST_CAP]));
    end
`ifdef IO_TIMER_CAPTURE_EN
  logic [2:0] cap_sync;
  assign cap_set = cap_sync[1] && !cap_sync[2];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cap_sync <= '0;
      capture  <= '0;
    end else begin
      cap_sync <= {cap_sync[1:0], capture_i};
      capture  <= cap_set ? count : capture;
    end
`else
  logic unused_capture;
  assign unused_capture = capture_i;
  assign cap_set = 1'b0;
  assign capture = 8'h00;
`endif
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed scoreboard bench for io_timer
module tb_io_timer;
  logic clk_i = 1'b0, rst_i = 1'b1, io_we_i = 1'b0, capture_i = 1'b0, chk_vld = 1'b0;
  logic [7:0] io_addr_i = 8'h00, io_data_i = 8'h00, io_data_o;
  logic irq_o;
  int tests = 0, fails = 0;
  typedef struct {
    string      n;
    logic [7:0] d;
    int         i;
  } exp_t;
  exp_t q[$];
  always #5 clk_i = ~clk_i;
  io_timer dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .io_addr_i(io_addr_i),
    .io_data_i(io_data_i),
    .io_we_i  (io_we_i),
    .io_data_o(io_data_o),
    .irq_o    (irq_o),
    .capture_i(capture_i)
  );
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    io_addr_i = a;
    io_data_i = d;
    io_we_i = 1'b1;
    step();
    io_we_i = 1'b0;
  endtask
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] d, input int i);
    exp_t e;
    e.n = n;
    e.d = d;
    e.i = i;
    io_addr_i = a;
    q.push_back(e);
    chk_vld = 1'b1;
    step();
    chk_vld = 1'b0;
  endtask
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (chk_vld) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty got no entry required one");
      end else begin
        e = q.pop_front();
        tests++;
        if (io_data_o !== e.d) begin
          fails++;
          $display("FAIL %s data got %h required %h", e.n, io_data_o, e.d);
        end
        if (e.i != 2) begin
          tests++;
          if (irq_o !== e.i[0]) begin
            fails++;
            $display("FAIL %s irq got %b required %0d", e.n, irq_o, e.i);
          end
        end
      end
    end
  end
  initial begin
    step();
    chk("rst_held_count", 8'h13, 8'hFF, 0);
    rst_i = 1'b0;
    chk("rst_reload", 8'h12, 8'hFF, 0);
    chk("rst_count", 8'h13, 8'hFF, 0);
    chk("rst_ctrl", 8'h10, 8'h00, 0);
    chk("rst_status", 8'h14, 8'h00, 0);
    chk("rst_unmapped", 8'h16, 8'h00, 0);
    wr(8'h11, 8'd3);
    wr(8'h12, 8'd4);
    wr(8'h13, 8'd4);
    wr(8'h10, 8'h03);
    repeat (19) step();
    chk("per_pre_ovf1", 8'h14, 8'h04, 0);
    chk("per_ovf1", 8'h14, 8'h05, 1);
    wr(8'h14, 8'h01);
    chk("per_clear", 8'h14, 8'h04, 0);
    repeat (16) step();
    chk("per_pre_ovf2", 8'h14, 8'h04, 0);
    chk("per_ovf2", 8'h14, 8'h05, 1);
    chk("per_reloaded", 8'h13, 8'h04, 1);
    wr(8'h14, 8'h01);
    chk("w1c_clear", 8'h14, 8'h04, 0);
    repeat (15) step();
    wr(8'h14, 8'h01);
    chk("w1c_race_kept", 8'h14, 8'h05, 1);
    wr(8'h14, 8'h01);
    chk("w1c_lone_clear", 8'h14, 8'h04, 0);
    wr(8'h13, 8'h50);
    chk("prio_count_wr", 8'h13, 8'h50, 0);
    repeat (2) step();
    chk("prio_hold", 8'h13, 8'h50, 0);
    chk("prio_next_tick", 8'h13, 8'h4F, 0);
    wr(8'h10, 8'h00);
    chk("stop_status", 8'h14, 8'h00, 0);
    chk("stop_count", 8'h13, 8'h4F, 0);
    repeat (5) step();
    chk("stop_count_hold", 8'h13, 8'h4F, 0);
    wr(8'h16, 8'hAA);
    chk("unmapped_wr", 8'h16, 8'h00, 0);
    wr(8'h15, 8'hAA);
    chk("capture_ro", 8'h15, 8'h00, 0);
    wr(8'h14, 8'h04);
    chk("run_ro", 8'h14, 8'h00, 0);
    wr(8'h10, 8'h08);
    chk("cap_ie_rw", 8'h10, 8'h08, 0);
    wr(8'h10, 8'h03);
    repeat (3) step();
    #2 rst_i = 1'b1;
    chk("async_count", 8'h13, 8'hFF, 0);
    chk("async_ctrl", 8'h10, 8'h00, 0);
    chk("async_presc", 8'h11, 8'h00, 0);
    rst_i = 1'b0;
    wr(8'h12, 8'd4);
    wr(8'h11, 8'd0);
    wr(8'h13, 8'd2);
    wr(8'h10, 8'h05);
    chk("os_running", 8'h14, 8'h04, 0);
    chk("os_count1", 8'h13, 8'h01, 0);
    chk("os_count0", 8'h13, 8'h00, 0);
    chk("os_ovf_stop", 8'h14, 8'h01, 0);
    chk("os_en_clr", 8'h10, 8'h04, 0);
    chk("os_reload", 8'h13, 8'h04, 0);
    repeat (3) step();
    chk("os_hold", 8'h13, 8'h04, 0);
`ifdef IO_TIMER_CAPTURE_EN
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    wr(8'h11, 8'd0);
    wr(8'h13, 8'h80);
    wr(8'h10, 8'h09);
    capture_i = 1'b1;
    repeat (3) step();
    capture_i = 1'b0;
    chk("cap_value", 8'h15, 8'h7E, 1);
    chk("cap_status", 8'h14, 8'h06, 1);
`endif
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d entries required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
